// File: rtl/memshare_pipe_sched_pkg.sv
// Shared configuration for the memShare sequencer: state encoding and counter widths.
package memShare_config_pkg;

  localparam int MAX_ALLOC_SEQ_NUM = 6;
  localparam int PIPE_HOLD_MAX     = 8;

  localparam int ALLOC_SEQ_W = $clog2(MAX_ALLOC_SEQ_NUM + 2);
  localparam int HOLD_CNT_W  = $clog2(PIPE_HOLD_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PIPE_BEGIN = 3'd1,
    ST_SHIFT_GEN  = 3'd2,
    ST_SHIFT_OUT  = 3'd3,
    ST_DONE       = 3'd4
  } memShare_sched_state_e;

endpackage

// File: rtl/memshare_pipe_sched.sv
// Sequencer stepping SCU.memShare() through N allocation sequences, one pipeline
// cycle each: begin pulse, isGtr request/capture from the RFMU, then PIPE_HOLD shift-out cycles.
module memshare_pipe_sched
  import memShare_config_pkg::*;
#(
  parameter int PIPE_HOLD   = 2,
  parameter int ALLOC_SEQ_W = memShare_config_pkg::ALLOC_SEQ_W
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   memShare_start_i,
  input  logic [ALLOC_SEQ_W-1:0] allocSeq_num_i,
  input  logic                   abort_i,
  input  logic                   rfmu_gtr_valid_i,
  input  logic                   rfmu_gtr_i,
  output logic                   scu_memShare_busy_o,
  output logic                   pipeCycle_begin_o,
  output logic                   shiftGen_rqst_o,
  output logic                   isGtr_o,
  output logic [ALLOC_SEQ_W-1:0] allocSeq_cnt_o,
  output logic                   memShare_done_o
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(PIPE_HOLD - 1);

  memShare_sched_state_e r_state;
  memShare_sched_state_e w_nextState;

  logic [ALLOC_SEQ_W-1:0] r_allocSeqNum;
  logic [ALLOC_SEQ_W-1:0] r_allocSeqCnt;
  logic [HOLD_CNT_W-1:0]  r_holdCnt;
  logic                   r_isGtr;

  logic w_startAccept;
  logic w_gtrLoad;
  logic w_seqInc;
  logic w_clear;
  logic w_lastSeq;

  assign w_lastSeq = (r_allocSeqCnt == (r_allocSeqNum - ALLOC_SEQ_W'(1)));

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort overrides every transition out of a non-IDLE state; in IDLE it only vetoes a start.
  always_comb begin
    w_nextState         = r_state;
    w_startAccept       = 1'b0;
    w_gtrLoad           = 1'b0;
    w_seqInc            = 1'b0;
    w_clear             = 1'b0;
    scu_memShare_busy_o = 1'b1;
    pipeCycle_begin_o   = 1'b0;
    shiftGen_rqst_o     = 1'b0;
    memShare_done_o     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        scu_memShare_busy_o = 1'b0;
        if (memShare_start_i && !abort_i && (allocSeq_num_i != '0)) begin
          w_startAccept = 1'b1;
          w_nextState   = ST_PIPE_BEGIN;
        end
      end
      ST_PIPE_BEGIN: begin
        pipeCycle_begin_o = 1'b1;
        w_nextState       = ST_SHIFT_GEN;
      end
      ST_SHIFT_GEN: begin
        shiftGen_rqst_o = 1'b1;
        if (rfmu_gtr_valid_i) begin
          w_gtrLoad   = 1'b1;
          w_nextState = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (r_holdCnt == '0) begin
          if (w_lastSeq) begin
            w_nextState = ST_DONE;
          end else begin
            w_seqInc    = 1'b1;
            w_nextState = ST_PIPE_BEGIN;
          end
        end
      end
      ST_DONE: begin
        memShare_done_o = 1'b1;
        w_nextState     = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    if (abort_i && (r_state != ST_IDLE)) begin
      w_nextState = ST_IDLE;
      w_clear     = 1'b1;
      w_gtrLoad   = 1'b0;
      w_seqInc    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_allocSeqNum <= '0;
      r_allocSeqCnt <= '0;
      r_holdCnt     <= '0;
      r_isGtr       <= 1'b0;
    end else if (w_clear || w_startAccept) begin
      r_allocSeqCnt <= '0;
      r_holdCnt     <= '0;
      r_isGtr       <= 1'b0;
      if (w_startAccept) begin
        r_allocSeqNum <= allocSeq_num_i;
      end
    end else begin
      if (w_gtrLoad) begin
        r_isGtr   <= rfmu_gtr_i;
        r_holdCnt <= HOLD_LOAD;
      end else if ((r_state == ST_SHIFT_OUT) && (r_holdCnt != '0)) begin
        r_holdCnt <= r_holdCnt - HOLD_CNT_W'(1);
      end
      if (w_seqInc) begin
        r_allocSeqCnt <= r_allocSeqCnt + ALLOC_SEQ_W'(1);
      end
    end
  end

  assign isGtr_o        = r_isGtr;
  assign allocSeq_cnt_o = r_allocSeqCnt;

endmodule
